// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load-op codes, MEM->WB bus field offsets and bus widths.
// MEM packs the bus with these offsets; WB unpacks it with the same ones.
package pipe_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;

    function automatic int bl_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Bus layout, MSB to LSB: {gr_we, dest, ld_op[2:0], addr_lo, excp, result, pc}
    function automatic int pc_lsb(input int xlen);
        return 0;
    endfunction

    function automatic int res_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int excp_bit(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int addr_lsb(input int xlen);
        return 2 * xlen + 1;
    endfunction

    function automatic int ldop_lsb(input int xlen);
        return addr_lsb(xlen) + bl_w(xlen);
    endfunction

    function automatic int dest_lsb(input int xlen);
        return ldop_lsb(xlen) + 3;
    endfunction

    function automatic int grwe_bit(input int xlen, input int rf_aw);
        return dest_lsb(xlen) + rf_aw;
    endfunction

    function automatic int bus_w(input int xlen, input int rf_aw);
        return 1 + rf_aw + 3 + bl_w(xlen) + 1 + 2 * xlen;
    endfunction

    function automatic int fwd_w(input int xlen, input int rf_aw);
        return 2 + rf_aw + xlen;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data alignment: shifts the loaded word down by the byte offset,
// then sign- or zero-extends the selected byte/half/word to XLEN.
module wb_load_align
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BL   = 2
) (
    input  logic [2:0]      ld_op_i,
    input  logic [BL-1:0]   addr_lo_i,
    input  logic [XLEN-1:0] result_i,
    output logic [XLEN-1:0] wdata_o
);

    logic [BL+2:0]   shamt;
    logic [XLEN-1:0] raw;

    // Keep the low nbits of v; fill the rest with v[nbits-1] (signed) or zero.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int nbits,
                                               input logic sgn);
        logic [XLEN-1:0] r;
        logic            fill;
        fill = sgn & v[nbits-1];
        for (int i = 0; i < XLEN; i++) begin
            r[i] = (i < nbits) ? v[i] : fill;
        end
        return r;
    endfunction

    always_comb begin
        shamt   = {addr_lo_i, 3'b000};
        raw     = result_i >> shamt;
        wdata_o = result_i;
        case (ld_op_i)
            LD_B:    wdata_o = extend(raw, 8, 1'b1);
            LD_BU:   wdata_o = extend(raw, 8, 1'b0);
            LD_H:    wdata_o = extend(raw, 16, 1'b1);
            LD_HU:   wdata_o = extend(raw, 16, 1'b0);
            LD_W:    wdata_o = extend(raw, 32, 1'b1);
            default: wdata_o = result_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_ext.sv
// Writeback stage: latches the MEM->WB bus, drives the regfile write port, bypass bus and flush.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter with clear input.
module wb_stage_ext
    import pipe_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int RF_AW = 5,
    localparam int BL    = bl_w(XLEN),
    localparam int BUS_W = bus_w(XLEN, RF_AW),
    localparam int FWD_W = fwd_w(XLEN, RF_AW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_stall,
    output logic              wb_allowin,
    input  logic              mem_to_wb_valid,
    input  logic [BUS_W-1:0]  mem_to_wb_bus,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [FWD_W-1:0]  wb_fwd_bus,
    output logic              wb_flush,
    output logic [XLEN-1:0]   wb_flush_pc,
`ifdef WB_RETIRE_CNT_EN
    input  logic              retire_cnt_clr,
    output logic [63:0]       retire_cnt,
`endif
    output logic [XLEN-1:0]   debug_wb_pc,
    output logic [XLEN/8-1:0] debug_wb_rf_we,
    output logic [RF_AW-1:0]  debug_wb_rf_wnum,
    output logic [XLEN-1:0]   debug_wb_rf_wdata
);

    localparam int OFF_PC   = pc_lsb(XLEN);
    localparam int OFF_RES  = res_lsb(XLEN);
    localparam int OFF_EXCP = excp_bit(XLEN);
    localparam int OFF_ADDR = addr_lsb(XLEN);
    localparam int OFF_LDOP = ldop_lsb(XLEN);
    localparam int OFF_DEST = dest_lsb(XLEN);
    localparam int OFF_GRWE = grwe_bit(XLEN, RF_AW);

    logic             wb_valid_q, wb_valid_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic             wb_flush_q, wb_flush_d;
    logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

    logic             wb_ready_go;
    logic             retire;
    logic             rf_we_w;
    logic [XLEN-1:0]  wdata_w;

    logic [XLEN-1:0]  e_pc;
    logic [XLEN-1:0]  e_result;
    logic             e_excp;
    logic [BL-1:0]    e_addr_lo;
    logic [2:0]       e_ld_op;
    logic [RF_AW-1:0] e_dest;
    logic             e_gr_we;

    assign e_pc      = bus_q[OFF_PC   +: XLEN];
    assign e_result  = bus_q[OFF_RES  +: XLEN];
    assign e_excp    = bus_q[OFF_EXCP];
    assign e_addr_lo = bus_q[OFF_ADDR +: BL];
    assign e_ld_op   = bus_q[OFF_LDOP +: 3];
    assign e_dest    = bus_q[OFF_DEST +: RF_AW];
    assign e_gr_we   = bus_q[OFF_GRWE];

    assign wb_ready_go = !wb_stall;
    assign wb_allowin  = !wb_valid_q || wb_ready_go;
    assign retire      = wb_valid_q && wb_ready_go;

    always_comb begin
        wb_valid_d = wb_valid_q;
        bus_d      = bus_q;
        flush_pc_d = flush_pc_q;
        wb_flush_d = retire && e_excp;
        if (wb_allowin) begin
            wb_valid_d = mem_to_wb_valid;
        end
        if (mem_to_wb_valid && wb_allowin) begin
            bus_d = mem_to_wb_bus;
        end
        // A retiring exception squashes whatever MEM hands over on the same edge.
        if (wb_flush_d) begin
            wb_valid_d = 1'b0;
            flush_pc_d = e_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_flush_q <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_flush_q <= wb_flush_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q      <= bus_d;
        flush_pc_q <= flush_pc_d;
    end

    wb_load_align #(
        .XLEN (XLEN),
        .BL   (BL)
    ) u_align (
        .ld_op_i   (e_ld_op),
        .addr_lo_i (e_addr_lo),
        .result_i  (e_result),
        .wdata_o   (wdata_w)
    );

    // Held high across a stall; rewriting the same register value is harmless.
    assign rf_we_w = wb_valid_q && e_gr_we && !e_excp && (e_dest != '0);

    assign rf_we             = rf_we_w;
    assign rf_waddr          = e_dest;
    assign rf_wdata          = wdata_w;
    assign wb_fwd_bus        = {wb_valid_q, rf_we_w, e_dest, wdata_w};
    assign wb_flush          = wb_flush_q;
    assign wb_flush_pc       = flush_pc_q;
    assign debug_wb_pc       = e_pc;
    assign debug_wb_rf_we    = {(XLEN/8){rf_we_w}};
    assign debug_wb_rf_wnum  = e_dest;
    assign debug_wb_rf_wdata = wdata_w;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire_cnt_clr) begin
            retire_cnt_d = '0;
        end else if (retire && !e_excp) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_ext.sv
// Self-checking bench for wb_stage_ext (XLEN=32): directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage_ext;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [2:0]  ld_op;
        logic [1:0]  addr_lo;
        logic        excp;
        logic [31:0] result;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_stall = 1'b0;
    logic        wb_allowin;
    logic        mem_to_wb_valid = 1'b0;
    logic [75:0] mem_to_wb_bus = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [38:0] wb_fwd_bus;
    logic        wb_flush;
    logic [31:0] wb_flush_pc;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic        retire_cnt_clr = 1'b0;
    logic [63:0] retire_cnt;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_stage_ext #(.XLEN(32), .RF_AW(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_stall          (wb_stall),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_fwd_bus        (wb_fwd_bus),
        .wb_flush          (wb_flush),
        .wb_flush_pc       (wb_flush_pc),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt_clr    (retire_cnt_clr),
        .retire_cnt        (retire_cnt),
`endif
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic gr_we, input logic [4:0] dest, input logic [2:0] ld_op,
                                  input logic [1:0] addr_lo, input logic excp,
                                  input logic [31:0] result, input logic [31:0] pc);
        entry_t e;
        e.gr_we = gr_we; e.dest = dest; e.ld_op = ld_op; e.addr_lo = addr_lo;
        e.excp = excp; e.result = result; e.pc = pc;
        return e;
    endfunction

    // Reference load result, from integer arithmetic on the addressed bytes.
    function automatic logic [31:0] model_wdata(input entry_t e);
        logic [31:0] raw;
        int          v;
        raw = e.result >> (8 * e.addr_lo);
        case (e.ld_op)
            3'd1: begin v = int'(raw % 256);   if (v >= 128)   v -= 256;   return 32'(v); end
            3'd2: return raw % 256;
            3'd3: begin v = int'(raw % 65536); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd4: return raw % 65536;
            3'd5: return raw;
            default: return e.result;
        endcase
    endfunction

    // Behavioural model of WB occupancy, flush and retire count.
    logic        m_known = 1'b0;
    logic        m_valid = 1'b0;
    entry_t      m_e = '0;
    logic        m_flush = 1'b0;
    logic [31:0] m_flush_pc = '0;
    logic [63:0] m_cnt = '0;

    always @(posedge clk) begin
        logic can_take;
        logic retiring;
        if (reset) begin
            m_known <= 1'b1;
            m_valid <= 1'b0;
            m_flush <= 1'b0;
            m_cnt   <= '0;
        end else begin
            retiring = m_valid && !wb_stall;
            can_take = !m_valid || !wb_stall;
            m_flush <= retiring && m_e.excp;
            if (retiring && m_e.excp) m_flush_pc <= m_e.pc;
`ifdef WB_RETIRE_CNT_EN
            if (retire_cnt_clr) m_cnt <= '0;
            else if (retiring && !m_e.excp) m_cnt <= m_cnt + 64'd1;
`endif
            if (retiring && m_e.excp) m_valid <= 1'b0;
            else if (can_take) m_valid <= mem_to_wb_valid;
            if (can_take && mem_to_wb_valid) m_e <= entry_t'(mem_to_wb_bus);
        end
    end

    always @(negedge clk) begin
        logic        exp_we;
        logic [31:0] exp_wd;
        if (m_known) begin
            exp_we = m_valid && m_e.gr_we && !m_e.excp && (m_e.dest != 5'd0);
            exp_wd = model_wdata(m_e);
            check("allowin", 64'(wb_allowin), 64'(!m_valid || !wb_stall));
            check("fwd_valid", 64'(wb_fwd_bus[38]), 64'(m_valid));
            check("flush", 64'(wb_flush), 64'(m_flush));
            if (m_flush) check("flush_pc", 64'(wb_flush_pc), 64'(m_flush_pc));
            check("rf_we", 64'(rf_we), 64'(exp_we));
            check("fwd_we", 64'(wb_fwd_bus[37]), 64'(exp_we));
            check("dbg_we", 64'(debug_wb_rf_we), exp_we ? 64'hF : 64'h0);
            if (m_valid) begin
                check("waddr", 64'(rf_waddr), 64'(m_e.dest));
                check("wdata", 64'(rf_wdata), 64'(exp_wd));
                check("dbg_pc", 64'(debug_wb_pc), 64'(m_e.pc));
                check("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(m_e.dest));
                check("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(exp_wd));
                check("fwd_dest", 64'(wb_fwd_bus[36:32]), 64'(m_e.dest));
                check("fwd_wdata", 64'(wb_fwd_bus[31:0]), 64'(exp_wd));
            end
`ifdef WB_RETIRE_CNT_EN
            check("retire_cnt", retire_cnt, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input entry_t e);
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = e;
    endtask

    task automatic idle();
        mem_to_wb_valid = 1'b0;
    endtask

    initial begin
        entry_t a, b;

        // Reset held two edges while MEM keeps offering
        offer(mk(1, 5'd5, 3'd0, 2'd0, 1'b1, 32'h1111_1111, 32'h1C00_0000));
        tick();
        @(negedge clk);
        check("rst_valid", 64'(wb_fwd_bus[38]), 64'h0);
        check("rst_rf_we", 64'(rf_we), 64'h0);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("rst_flush", 64'(wb_flush), 64'h0);
        check("rst_dbg_we", 64'(debug_wb_rf_we), 64'h0);

        // ALU write
        offer(mk(1, 5'd5, 3'd0, 2'd0, 1'b0, 32'h1234_5678, 32'h1C00_0004));
        tick();
        idle();
        @(negedge clk);
        check("alu_we", 64'(rf_we), 64'h1);
        check("alu_waddr", 64'(rf_waddr), 64'd5);
        check("alu_wdata", 64'(rf_wdata), 64'h1234_5678);
        check("alu_dbg_we", 64'(debug_wb_rf_we), 64'hF);

        // LB, LBU, LH on 0x80FF_7F01
        offer(mk(1, 5'd6, 3'd1, 2'd3, 1'b0, 32'h80FF_7F01, 32'h1C00_0008));
        tick();
        offer(mk(1, 5'd6, 3'd2, 2'd3, 1'b0, 32'h80FF_7F01, 32'h1C00_000C));
        @(negedge clk);
        check("lb_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
        tick();
        offer(mk(1, 5'd6, 3'd3, 2'd2, 1'b0, 32'h80FF_7F01, 32'h1C00_0010));
        @(negedge clk);
        check("lbu_wdata", 64'(rf_wdata), 64'h0000_0080);
        tick();
        idle();
        @(negedge clk);
        check("lh_wdata", 64'(rf_wdata), 64'hFFFF_80FF);

        // Stall for three cycles with MEM valid
        a = mk(1, 5'd3, 3'd0, 2'd0, 1'b0, 32'hA5A5_0001, 32'h1C00_0100);
        b = mk(1, 5'd4, 3'd0, 2'd0, 1'b0, 32'h0000_BEEF, 32'h1C00_0104);
        offer(a);
        tick();
        wb_stall = 1'b1;
        offer(b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_allowin", 64'(wb_allowin), 64'h0);
            check("stall_wdata", 64'(rf_wdata), 64'hA5A5_0001);
            check("stall_pc", 64'(debug_wb_pc), 64'h1C00_0100);
            check("stall_we", 64'(rf_we), 64'h1);
            tick();
        end
        wb_stall = 1'b0;
        @(negedge clk);
        check("unstall_allowin", 64'(wb_allowin), 64'h1);
        check("unstall_hold", 64'(rf_wdata), 64'hA5A5_0001);
        tick();
        idle();
        @(negedge clk);
        check("next_wdata", 64'(rf_wdata), 64'h0000_BEEF);
        check("next_pc", 64'(debug_wb_pc), 64'h1C00_0104);

        // Exception: no write, one-cycle flush, younger entry squashed
        offer(mk(1, 5'd7, 3'd0, 2'd0, 1'b1, 32'hDEAD_0000, 32'h1C00_0040));
`ifdef WB_RETIRE_CNT_EN
        retire_cnt_clr = 1'b1;
`endif
        tick();
`ifdef WB_RETIRE_CNT_EN
        retire_cnt_clr = 1'b0;
`endif
        offer(mk(1, 5'd9, 3'd0, 2'd0, 1'b0, 32'h0000_0009, 32'h1C00_0044));
        @(negedge clk);
        check("excp_we", 64'(rf_we), 64'h0);
        check("excp_no_flush_yet", 64'(wb_flush), 64'h0);
        tick();
        idle();
        @(negedge clk);
        check("flush_pulse", 64'(wb_flush), 64'h1);
        check("flush_pc_lit", 64'(wb_flush_pc), 64'h1C00_0040);
        check("squash_valid", 64'(wb_fwd_bus[38]), 64'h0);
`ifdef WB_RETIRE_CNT_EN
        check("excp_no_count", retire_cnt, 64'h0);
`endif
        tick();
        @(negedge clk);
        check("flush_one_cycle", 64'(wb_flush), 64'h0);

        // Randomized traffic, including occasional mid-run resets
        for (int i = 0; i < 800; i++) begin
            entry_t e;
            tick();
            reset    = ($urandom_range(0, 79) == 0);
            wb_stall = ($urandom_range(0, 3) == 0);
            e = mk(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0) ? 32'h80FF_7F01 : $urandom(),
                   $urandom());
            if ($urandom_range(0, 3) != 0) offer(e);
            else idle();
`ifdef WB_RETIRE_CNT_EN
            retire_cnt_clr = ($urandom_range(0, 49) == 0);
`endif
        end
        tick();
        reset = 1'b0;
        wb_stall = 1'b0;
        idle();
        tick();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
